// File: rtl/bus_arbiter_2m_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_2m_if
// Groups the request, grant and handshake signals between the two bus
// masters (or the testbench standing in for them), the selected slave's
// HREADY, and the round-robin arbiter.
//
// Parameters:
//   BLEN_W      width of the burst-length fields
//
// Signals:
//   HBUSREQ_M1/M2   master bus requests
//   HBLEN_M1/M2     requested burst lengths (0 encodes 2^BLEN_W beats)
//   HREADY          selected slave ready; a beat completes when high
//   HGRANT_M1/M2    bus ownership grants
//   HMASTER         master-select code: 00 none, 01 M1, 10 M2
//   HLAST           one-cycle pulse after the final beat of a grant
//   ARB_ERR         one-cycle pulse on a timeout release
//
// Modports:
//   master  requester side: drives requests, lengths and HREADY
//   slave   arbiter side: samples requests, drives grants and status
// ---------------------------------------------------------------------------
interface bus_arbiter_2m_if #(
    parameter int BLEN_W = 4
);
    logic              HBUSREQ_M1;
    logic              HBUSREQ_M2;
    logic [BLEN_W-1:0] HBLEN_M1;
    logic [BLEN_W-1:0] HBLEN_M2;
    logic              HREADY;
    logic              HGRANT_M1;
    logic              HGRANT_M2;
    logic [1:0]        HMASTER;
    logic              HLAST;
    logic              ARB_ERR;

    modport master (
        output HBUSREQ_M1, HBUSREQ_M2, HBLEN_M1, HBLEN_M2, HREADY,
        input  HGRANT_M1, HGRANT_M2, HMASTER, HLAST, ARB_ERR
    );

    modport slave (
        input  HBUSREQ_M1, HBUSREQ_M2, HBLEN_M1, HBLEN_M2, HREADY,
        output HGRANT_M1, HGRANT_M2, HMASTER, HLAST, ARB_ERR
    );
endinterface

// File: rtl/bus_arbiter_2m.sv
// ---------------------------------------------------------------------------
// bus_arbiter_2m
// Two-master round-robin arbiter for the shared system bus. A master is
// granted for the number of beats it requested; beats are counted on edges
// where HREADY is high. The bus is released at burst end, when the owner
// drops its request, or (optionally) after too many HREADY-low cycles.
// Arbitration re-runs on the releasing edge, so ownership can hand over
// back-to-back with no idle cycle.
//
// Parameters:
//   BLEN_W       burst-length width; length 0 encodes 2^BLEN_W beats
//   TIMEOUT_CYC  consecutive HREADY-low busy cycles before forced release
//   TO_W         timeout counter width, 2^TO_W must exceed TIMEOUT_CYC
//
// Ports:
//   HCLK      bus clock, rising edge
//   HRESETn   asynchronous active-low reset
//   bus       bus_arbiter_2m_if.slave (requests, lengths, HREADY in;
//             grants, HMASTER, HLAST, ARB_ERR out)
//
// Build option:
//   ARB_TIMEOUT_EN  when defined, adds the HREADY-low timeout counter and
//                   drives ARB_ERR; when undefined ARB_ERR is tied low and a
//                   grant is held until burst end or request drop.
// ---------------------------------------------------------------------------
module bus_arbiter_2m #(
    parameter int BLEN_W      = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 5
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    bus_arbiter_2m_if.slave    bus
);

    // State encoding doubles as the HMASTER code, so grants and HMASTER come
    // straight from the state register and can never disagree.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_M1 = 2'b01,
        OWN_M2 = 2'b10
    } state_t;

    localparam logic [BLEN_W:0] FULL_BURST = {1'b1, {BLEN_W{1'b0}}};
    localparam logic [BLEN_W:0] ONE_BEAT   = {{BLEN_W{1'b0}}, 1'b1};

    // Catch an undersized timeout counter at elaboration.
    if ((2 ** TO_W) <= TIMEOUT_CYC) begin : g_badTimeoutWidth
        $error("bus_arbiter_2m: TO_W too small for TIMEOUT_CYC");
    end

    state_t          r_state;
    state_t          w_nextState;
    logic [BLEN_W:0] r_beatsLeft;
    logic [BLEN_W:0] w_beatsNext;
    logic            r_lastOwnerM2;
    logic            w_lastOwnerNext;
    logic            r_hlast;
    logic            w_busy;
    logic            w_ownerReq;
    logic            w_finalBeat;
    logic            w_timeout;
    logic            w_release;
    logic            w_arbitrate;

    function automatic logic [BLEN_W:0] burstLen(input logic [BLEN_W-1:0] len);
        return (len == '0) ? FULL_BURST : {1'b0, len};
    endfunction

    // Release conditions for the current owner. A final beat counts as burst
    // completion (HLAST) even if the request falls on that same edge.
    always_comb begin
        w_busy      = (r_state != IDLE);
        w_ownerReq  = 1'b0;
        if (r_state == OWN_M1) begin
            w_ownerReq = bus.HBUSREQ_M1;
        end else if (r_state == OWN_M2) begin
            w_ownerReq = bus.HBUSREQ_M2;
        end
        w_finalBeat = w_busy && bus.HREADY && (r_beatsLeft == ONE_BEAT);
        w_release   = w_busy && (w_finalBeat || !w_ownerReq || w_timeout);
        w_arbitrate = !w_busy || w_release;
    end

    // Next-state: arbitrate when idle or releasing; otherwise count beats.
    // On a tie the master that did not own the bus last wins.
    always_comb begin
        w_nextState     = r_state;
        w_beatsNext     = r_beatsLeft;
        w_lastOwnerNext = r_lastOwnerM2;
        if (w_arbitrate) begin
            if (bus.HBUSREQ_M1 && (!bus.HBUSREQ_M2 || r_lastOwnerM2)) begin
                w_nextState     = OWN_M1;
                w_beatsNext     = burstLen(bus.HBLEN_M1);
                w_lastOwnerNext = 1'b0;
            end else if (bus.HBUSREQ_M2) begin
                w_nextState     = OWN_M2;
                w_beatsNext     = burstLen(bus.HBLEN_M2);
                w_lastOwnerNext = 1'b1;
            end else begin
                w_nextState     = IDLE;
            end
        end else if (bus.HREADY) begin
            w_beatsNext = r_beatsLeft - ONE_BEAT;
        end
    end

    // State and counter registers; last owner resets to M2 so M1 wins the
    // first tie.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state       <= IDLE;
            r_beatsLeft   <= '0;
            r_lastOwnerM2 <= 1'b1;
            r_hlast       <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_beatsLeft   <= w_beatsNext;
            r_lastOwnerM2 <= w_lastOwnerNext;
            r_hlast       <= w_finalBeat;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] r_toCnt;
    logic            r_arbErr;

    // Fires on the edge that would make the count of consecutive busy
    // HREADY-low cycles reach TIMEOUT_CYC.
    assign w_timeout = w_busy && !bus.HREADY && (r_toCnt == TO_LAST);

    // The count restarts on any accepted beat and on every (re)grant.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_toCnt  <= '0;
            r_arbErr <= 1'b0;
        end else begin
            if (w_arbitrate || bus.HREADY) begin
                r_toCnt <= '0;
            end else begin
                r_toCnt <= r_toCnt + TO_ONE;
            end
            r_arbErr <= w_timeout;
        end
    end

    assign bus.ARB_ERR = r_arbErr;
`else
    assign w_timeout   = 1'b0;
    assign bus.ARB_ERR = 1'b0;
`endif

    assign bus.HGRANT_M1 = r_state[0];
    assign bus.HGRANT_M2 = r_state[1];
    assign bus.HMASTER   = r_state;
    assign bus.HLAST     = r_hlast;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_2m
// Self-checking bench for bus_arbiter_2m. Stimulus vectors hold inputs for
// one clock edge plus the outputs expected after that edge, packed as
// {HGRANT_M1, HGRANT_M2, HMASTER[1:0], HLAST, ARB_ERR}. Expected values are
// queued when a vector is driven and compared after the edge.
// Honours ARB_TIMEOUT_EN for the timeout sequence.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_2m;

    localparam logic [5:0] OUT_IDLE = 6'b00_00_0_0;
    localparam logic [5:0] OUT_M1   = 6'b10_01_0_0;
    localparam logic [5:0] OUT_M2   = 6'b01_10_0_0;
    localparam logic [5:0] LAST     = 6'b00_00_1_0;
    localparam logic [5:0] ERR      = 6'b00_00_0_1;

    typedef struct {
        string      name;
        logic       r1;
        logic       r2;
        logic [3:0] b1;
        logic [3:0] b2;
        logic       rdy;
        logic [5:0] exp;
    } vec_t;

    logic HCLK;
    logic HRESETn;

    bus_arbiter_2m_if #(.BLEN_W(4)) bus ();

    bus_arbiter_2m #(
        .BLEN_W     (4),
        .TIMEOUT_CYC(16),
        .TO_W       (5)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus.slave)
    );

    vec_t       vecs[$];
    logic [5:0] expQ[$];
    string      nameQ[$];
    int         errors = 0;
    int         checks = 0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(string name, logic r1, logic r2,
                                   logic [3:0] b1, logic [3:0] b2,
                                   logic rdy, logic [5:0] exp);
        vec_t v;
        v.name = name;
        v.r1   = r1;
        v.r2   = r2;
        v.b1   = b1;
        v.b2   = b2;
        v.rdy  = rdy;
        v.exp  = exp;
        vecs.push_back(v);
    endfunction

    // Pops the oldest expectation and compares it with the DUT outputs now.
    task automatic checkOutput();
        logic [5:0] exp;
        logic [5:0] got;
        string      name;
        got = {bus.HGRANT_M1, bus.HGRANT_M2, bus.HMASTER, bus.HLAST, bus.ARB_ERR};
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: output %b with no expectation queued", got);
        end else begin
            exp  = expQ.pop_front();
            name = nameQ.pop_front();
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s: got {g1,g2,hmaster,hlast,err}=%b required %b",
                         name, got, exp);
            end
        end
    endtask

    task automatic expectNow(string name, logic [5:0] exp);
        expQ.push_back(exp);
        nameQ.push_back(name);
        checkOutput();
    endtask

    // Drive one vector ahead of the rising edge, check #1 after it.
    task automatic applyStimulus(input vec_t v);
        @(negedge HCLK);
        bus.HBUSREQ_M1 = v.r1;
        bus.HBUSREQ_M2 = v.r2;
        bus.HBLEN_M1   = v.b1;
        bus.HBLEN_M2   = v.b2;
        bus.HREADY     = v.rdy;
        expQ.push_back(v.exp);
        nameQ.push_back(v.name);
        @(posedge HCLK);
        #1;
        checkOutput();
    endtask

    task automatic runTable();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end
        vecs.delete();
    endtask

    initial begin
        HRESETn        = 1'b0;
        bus.HBUSREQ_M1 = 1'b0;
        bus.HBUSREQ_M2 = 1'b0;
        bus.HBLEN_M1   = 4'd0;
        bus.HBLEN_M2   = 4'd0;
        bus.HREADY     = 1'b0;

        repeat (2) @(posedge HCLK);
        #1;
        expectNow("resetState", OUT_IDLE);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Both request from idle: M1 wins the first tie, then alternation
        // with no idle cycle between grants.
        addVec("rrGrantM1",    1, 1, 4'd2, 4'd3, 1, OUT_M1);
        addVec("rrM1Beat1",    1, 1, 4'd2, 4'd3, 1, OUT_M1);
        addVec("rrHandToM2",   1, 1, 4'd2, 4'd3, 1, OUT_M2 | LAST);
        addVec("rrM2Beat2",    1, 1, 4'd2, 4'd3, 1, OUT_M2);
        addVec("rrM2Beat3",    1, 1, 4'd2, 4'd3, 1, OUT_M2);
        addVec("rrBackToM1",   1, 1, 4'd2, 4'd3, 1, OUT_M1 | LAST);
        addVec("rrBothDrop",   0, 0, 4'd2, 4'd3, 1, OUT_IDLE);
        runTable();

        // Single M1 burst of 4; still requesting at the end so regranted,
        // then request drop releases without HLAST.
        addVec("m1Grant",      1, 0, 4'd4, 4'd0, 1, OUT_M1);
        addVec("m1Beat1",      1, 0, 4'd4, 4'd0, 1, OUT_M1);
        addVec("m1Beat2",      1, 0, 4'd4, 4'd0, 1, OUT_M1);
        addVec("m1Beat3",      1, 0, 4'd4, 4'd0, 1, OUT_M1);
        addVec("m1Beat4Last",  1, 0, 4'd4, 4'd0, 1, OUT_M1 | LAST);
        addVec("m1DropIdle",   0, 0, 4'd4, 4'd0, 1, OUT_IDLE);
        addVec("idleStays",    0, 0, 4'd4, 4'd0, 1, OUT_IDLE);
        runTable();

        // M2 with length 0 (16 beats) and HREADY toggling: beats land on
        // even-numbered edges only, HLAST after the 16th.
        addVec("len0Grant", 0, 1, 4'd0, 4'd0, 1, OUT_M2);
        for (int k = 2; k <= 32; k++) begin
            addVec($sformatf("len0Edge%0d", k), 0, 1, 4'd0, 4'd0,
                   (k % 2 == 0), (k == 32) ? (OUT_M2 | LAST) : OUT_M2);
        end
        addVec("len0DropIdle", 0, 0, 4'd0, 4'd0, 1, OUT_IDLE);
        runTable();

        // Early drop after 3 beats hands the bus to the waiting M2, which
        // never preempted M1 before that.
        addVec("dropGrantM1",  1, 1, 4'd8, 4'd5, 1, OUT_M1);
        addVec("dropBeat1",    1, 1, 4'd8, 4'd5, 1, OUT_M1);
        addVec("dropBeat2",    1, 1, 4'd8, 4'd5, 1, OUT_M1);
        addVec("dropBeat3",    1, 1, 4'd8, 4'd5, 1, OUT_M1);
        addVec("dropToM2",     0, 1, 4'd8, 4'd5, 1, OUT_M2);
        addVec("dropM2Idle",   0, 0, 4'd8, 4'd5, 1, OUT_IDLE);
        runTable();

        // Reset mid-burst clears outputs without a clock edge.
        addVec("preRstGrant",  1, 0, 4'd8, 4'd0, 1, OUT_M1);
        addVec("preRstBeat",   1, 0, 4'd8, 4'd0, 1, OUT_M1);
        runTable();
        @(posedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        expectNow("asyncRstMidBurst", OUT_IDLE);
        @(posedge HCLK);
        #1;
        expectNow("heldInReset", OUT_IDLE);
        @(negedge HCLK);
        HRESETn = 1'b1;
        addVec("postRstTieM1", 1, 1, 4'd3, 4'd3, 1, OUT_M1);
        addVec("postRstIdle",  0, 0, 4'd3, 4'd3, 1, OUT_IDLE);
        runTable();

        // HREADY held low during an M1 grant with M2 waiting.
        addVec("toGrantM1", 1, 0, 4'd8, 4'd4, 1, OUT_M1);
        for (int k = 2; k <= 16; k++) begin
            addVec($sformatf("toWait%0d", k), 1, 1, 4'd8, 4'd4, 0, OUT_M1);
        end
`ifdef ARB_TIMEOUT_EN
        addVec("toExpire",   1, 1, 4'd8, 4'd4, 0, OUT_M2 | ERR);
        addVec("toAfterErr", 1, 1, 4'd8, 4'd4, 0, OUT_M2);
`else
        addVec("toNoExpire", 1, 1, 4'd8, 4'd4, 0, OUT_M1);
        addVec("toStillM1",  1, 1, 4'd8, 4'd4, 0, OUT_M1);
`endif
        addVec("toDropIdle", 0, 0, 4'd8, 4'd4, 0, OUT_IDLE);
        runTable();

        if (expQ.size() != 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL scoreboard: %0d expectations left unchecked", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
